box_motion_ctrl: RTL and testbench

- Upstream sequencer for the box-drawing datapath. Owns the box origin, direction and frame pacing.
- Each frame it runs this cycle: draw request, pause, erase request, move.
- Requests go to the datapath over a req/done handshake. The datapath's pixel writes then go to vga_adapter.
- The box bounces off all four screen edges (160x120 canvas).

---
 rtl/box_motion_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_box_motion_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/box_motion_ctrl.sv
// Frame sequencer for the bouncing-box demo: draw, pause, erase, move, repeat.
// Owns the box origin and direction and talks to the pixel datapath over req/done.
module box_motion_ctrl #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int BOX_SIZE    = 4,
  parameter int FRAME_TICKS = 12_500_000,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       go,
  input  logic [2:0] colour_in,
  input  logic       done,
  output logic       req,
  output logic       erase,
  output logic [7:0] box_x,
  output logic [6:0] box_y,
  output logic [2:0] colour,
  output logic       busy
);

  localparam int               CNT_W    = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_TICKS - 1);
  localparam logic [7:0]       X_LIM    = 8'(SCREEN_W - BOX_SIZE);
  localparam logic [6:0]       Y_LIM    = 7'(SCREEN_H - BOX_SIZE);
  localparam logic [7:0]       X_RST    = 8'(X_INIT);
  localparam logic [6:0]       Y_RST    = 7'(Y_INIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_PAUSE = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] pause_cnt;
  logic             dir_x_fwd;
  logic             dir_y_fwd;
  logic             ld_draw;
  logic             ld_erase;
  logic             ld_pause;
  logic             req_clr;
  logic             do_move;
  logic             pause_run;
  logic             done_seen;

  // Bounce-and-step for one axis; returns {forward_next, pos_next}.
  // A zero-length track (box as wide as the screen) pins the origin at 0.
  function automatic logic [8:0] step_x(input logic [7:0] pos, input logic fwd);
    logic [7:0] p;
    logic       f;
    f = fwd;
    if (X_LIM == 8'd0) begin
      p = 8'd0;
    end else if (fwd && pos == X_LIM) begin
      f = 1'b0;
      p = pos - 8'd1;
    end else if (!fwd && pos == 8'd0) begin
      f = 1'b1;
      p = pos + 8'd1;
    end else if (fwd) begin
      p = pos + 8'd1;
    end else begin
      p = pos - 8'd1;
    end
    return {f, p};
  endfunction

  function automatic logic [7:0] step_y(input logic [6:0] pos, input logic fwd);
    logic [6:0] p;
    logic       f;
    f = fwd;
    if (Y_LIM == 7'd0) begin
      p = 7'd0;
    end else if (fwd && pos == Y_LIM) begin
      f = 1'b0;
      p = pos - 7'd1;
    end else if (!fwd && pos == 7'd0) begin
      f = 1'b1;
      p = pos + 7'd1;
    end else if (fwd) begin
      p = pos + 7'd1;
    end else begin
      p = pos - 7'd1;
    end
    return {f, p};
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // done only counts while a request is actually outstanding
  assign done_seen = done && req;

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (go) next_state = S_DRAW;
      S_DRAW:  if (done_seen) next_state = S_PAUSE;
      S_PAUSE: if (pause_cnt == '0) next_state = S_ERASE;
      S_ERASE: if (done_seen) next_state = S_MOVE;
      S_MOVE:  next_state = S_DRAW;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ld_draw   = 1'b0;
    ld_erase  = 1'b0;
    ld_pause  = 1'b0;
    req_clr   = 1'b0;
    do_move   = 1'b0;
    pause_run = 1'b0;
    busy      = (state != S_IDLE);
    unique case (state)
      S_IDLE:  ld_draw = (next_state == S_DRAW);
      S_DRAW:  begin
        ld_pause = (next_state == S_PAUSE);
        req_clr  = (next_state == S_PAUSE);
      end
      S_PAUSE: begin
        pause_run = (pause_cnt != '0);
        ld_erase  = (next_state == S_ERASE);
      end
      S_ERASE: req_clr = (next_state == S_MOVE);
      S_MOVE:  begin
        do_move = 1'b1;
        ld_draw = 1'b1;
      end
      default: ;
    endcase
  end

  // Request outputs are registered so they only change at frame-phase boundaries.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      req    <= 1'b0;
      erase  <= 1'b0;
      colour <= 3'b000;
    end else if (ld_draw) begin
      req    <= 1'b1;
      erase  <= 1'b0;
      colour <= colour_in;
    end else if (ld_erase) begin
      req    <= 1'b1;
      erase  <= 1'b1;
      colour <= 3'b000;
    end else if (req_clr) begin
      req    <= 1'b0;
      erase  <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pause_cnt <= '0;
    end else if (ld_pause) begin
      pause_cnt <= CNT_LOAD;
    end else if (pause_run) begin
      pause_cnt <= pause_cnt - 1'b1;
    end
  end

  // Both axes step in the same cycle, so a corner hit flips both directions.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      box_x     <= X_RST;
      box_y     <= Y_RST;
      dir_x_fwd <= 1'b1;
      dir_y_fwd <= 1'b1;
    end else if (do_move) begin
      {dir_x_fwd, box_x} <= step_x(box_x, dir_x_fwd);
      {dir_y_fwd, box_y} <= step_y(box_y, dir_y_fwd);
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Bench for box_motion_ctrl on an 8x6 canvas with a 4-pixel box and 3-cycle pause.
module tb_box_motion_ctrl;

  localparam int SW = 8;
  localparam int SH = 6;
  localparam int BS = 4;
  localparam int FT = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [2:0] colour_in = 3'b000;
  logic       done = 1'b0;
  logic       req;
  logic       erase;
  logic [7:0] box_x;
  logic [6:0] box_y;
  logic [2:0] colour;
  logic       busy;

  int total = 0;
  int bad = 0;

  box_motion_ctrl #(
    .SCREEN_W(SW), .SCREEN_H(SH), .BOX_SIZE(BS),
    .FRAME_TICKS(FT), .X_INIT(0), .Y_INIT(0)
  ) dut (
    .clock(clock), .resetn(resetn), .go(go), .colour_in(colour_in),
    .done(done), .req(req), .erase(erase), .box_x(box_x),
    .box_y(box_y), .colour(colour), .busy(busy)
  );

  always #5 clock = ~clock;

  // Origin after n moves from 0 heading forward: a triangle wave over [0, span].
  function automatic int refl(input int n, input int span);
    int t;
    if (span == 0) return 0;
    t = n % (2 * span);
    return (t <= span) ? t : 2 * span - t;
  endfunction

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"}, 32'(req), 32'd0);
    chk({tag, "_erase"}, 32'(erase), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_x"}, 32'(box_x), 32'd0);
    chk({tag, "_y"}, 32'(box_y), 32'd0);
  endtask

  // Entered at a falling edge just before the DUT goes to DRAW (IDLE with go, or MOVE).
  task automatic do_frame(input int n, input logic [2:0] col, input int dly,
                          input bit spur, input bit abort_erase);
    int plen;
    int ex;
    int ey;
    ex = refl(n, SW - BS);
    ey = refl(n, SH - BS);
    colour_in = col;
    tick;
    chk("draw_req", 32'(req), 32'd1);
    chk("draw_erase", 32'(erase), 32'd0);
    chk("draw_colour", 32'(colour), 32'(col));
    chk("draw_x", 32'(box_x), 32'(ex));
    chk("draw_y", 32'(box_y), 32'(ey));
    chk("draw_busy", 32'(busy), 32'd1);
    for (int i = 1; i < dly; i++) begin
      colour_in = 3'($urandom);
      tick;
      chk("draw_hold_req", 32'(req), 32'd1);
      chk("draw_hold_colour", 32'(colour), 32'(col));
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    plen = 0;
    while (req == 1'b0 && plen < 20) begin
      if (spur) done = 1'($urandom);
      plen++;
      tick;
    end
    done = 1'b0;
    chk("pause_len", 32'(plen), 32'(FT));
    chk("erase_req", 32'(req), 32'd1);
    chk("erase_flag", 32'(erase), 32'd1);
    chk("erase_colour", 32'(colour), 32'd0);
    chk("erase_x", 32'(box_x), 32'(ex));
    chk("erase_y", 32'(box_y), 32'(ey));
    if (abort_erase) begin
      resetn = 1'b0;
      #1;
      check_idle("abort");
      chk("abort_colour", 32'(colour), 32'd0);
    end else begin
      for (int i = 1; i < dly; i++) begin
        colour_in = 3'($urandom);
        tick;
        chk("erase_hold_req", 32'(req), 32'd1);
        chk("erase_hold_flag", 32'(erase), 32'd1);
      end
      done = 1'b1;
      tick;
      done = 1'b0;
      chk("move_req", 32'(req), 32'd0);
      chk("move_erase", 32'(erase), 32'd0);
      chk("move_busy", 32'(busy), 32'd1);
    end
  endtask

  initial begin
    repeat (2) tick;
    check_idle("reset");
    chk("reset_colour", 32'(colour), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      done = 1'b1;
      tick;
      done = 1'b0;
      check_idle("idle_spur");
      tick;
    end

    go = 1'b1;
    do_frame(0, 3'b100, 5, 1'b0, 1'b0);
    go = 1'b0;
    for (int n = 1; n < 6; n++) do_frame(n, 3'($urandom), 5, (n == 3), 1'b0);

    do_frame(6, 3'b010, 5, 1'b1, 1'b1);
    repeat (3) begin
      tick;
      check_idle("in_reset");
    end
    resetn = 1'b1;
    repeat (3) begin
      tick;
      check_idle("post_reset");
    end

    go = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) go = 1'($urandom);
      do_frame(n, 3'($urandom), int'($urandom_range(1, 6)), 1'b1, 1'b0);
    end
    go = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
